dm_bridge: RTL and testbench

- Data-memory access bridge directly downstream of the pipelined CPU's MEM stage.
- Consumes the CPU's memory port: address, store data, write strobe and dm_ctrl access type.
- Drives a word-addressed, byte-enabled memory bus with a req/ack handshake.
- Returns aligned, sign/zero-extended load data and a ready/stall indication to the pipeline.

---
 rtl/dm_bridge_if.sv | 37 +++
 rtl/dm_bridge.sv | 199 +++++++++++++++++++
 tb/tb_dm_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_bridge_if.sv
// CPU-side and memory-side signal bundle for dm_bridge.
// master: the bridge itself; slave: the CPU pipeline and memory bus around it.
interface dm_bridge_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_dmtype;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic              cpu_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_err, cpu_stall,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_err, cpu_stall,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_bridge.sv
// Data-memory bridge: CPU MEM-stage port to word-addressed, byte-enabled req/ack bus.
// Optional WAIT-state timeout enabled by defining DM_TIMEOUT_EN.
module dm_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  dm_bridge_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("dm_bridge: TIMEOUT_CYCLES must be nonzero");
  end

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        lane_q, lane_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              cpu_err_q, cpu_err_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;

`ifdef DM_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  size_e       size_in;
  logic        sext_in;
  logic [1:0]  lane_in;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  // Request decode; reserved dmtype codes fall through to word.
  always_comb begin
    lane_in = bus.cpu_addr[1:0];
    size_in = SZ_WORD;
    sext_in = 1'b0;
    case (bus.cpu_dmtype)
      3'b001:  begin size_in = SZ_HALF; sext_in = 1'b1; end
      3'b010:  size_in = SZ_HALF;
      3'b011:  begin size_in = SZ_BYTE; sext_in = 1'b1; end
      3'b100:  size_in = SZ_BYTE;
      default: size_in = SZ_WORD;
    endcase
    misaligned = ((size_in == SZ_WORD) && (lane_in != 2'b00)) ||
                 ((size_in == SZ_HALF) && lane_in[0]);
  end

  always_comb begin
    ld_byte = 8'(bus.mem_rdata >> {lane_q, 3'b000});
    ld_half = 16'(bus.mem_rdata >> {lane_q[1], 4'b0000});
    case (size_q)
      SZ_BYTE: load_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = {{16{sext_q & ld_half[15]}}, ld_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = cpu_err_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef DM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          size_d = size_in;
          sext_d = sext_in;
          lane_d = lane_in;
          if (misaligned) begin
            state_d     = S_DONE;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d    = S_WAIT;
            mem_req_d  = 1'b1;
            mem_we_d   = bus.cpu_we;
            mem_addr_d = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
            mem_be_d   = 4'b1111;
            mem_wdata_d = bus.cpu_wdata;
            if (bus.cpu_we) begin
              case (size_in)
                SZ_BYTE: begin
                  mem_be_d    = 4'b0001 << lane_in;
                  mem_wdata_d = {4{bus.cpu_wdata[7:0]}};
                end
                SZ_HALF: begin
                  mem_be_d    = lane_in[1] ? 4'b1100 : 4'b0011;
                  mem_wdata_d = {2{bus.cpu_wdata[15:0]}};
                end
                default: ;
              endcase
            end
`ifdef DM_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b0;
          cpu_rdata_d = mem_we_q ? '0 : load_val;
        end
`ifdef DM_TIMEOUT_EN
        // Ack on the limit cycle takes the branch above, so it wins.
        else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        // Without a timeout the bus is trusted to acknowledge eventually.
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      size_q      <= SZ_WORD;
      sext_q      <= 1'b0;
      lane_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
`ifdef DM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef DM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ready_q;

endmodule

// File: tb/tb_dm_bridge.sv
// Randomized bench for dm_bridge, checked every cycle against a transaction-level model.
// Build with DM_TIMEOUT_EN defined to exercise the WAIT-state timeout.
module tb_dm_bridge;

  typedef enum {M_SKIP, M_IDLE, M_TXN} mode_e;

`ifdef DM_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 0;
`endif

  logic clk;
  logic rst;

  dm_bridge_if #(.ADDR_W(32)) bus ();

  dm_bridge #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  mode_e       mode;
  int          k;
  logic        tx_we;
  logic [31:0] tx_addr;
  logic        tx_mis;
  int          tx_r;
  int          tx_abort;
  logic [31:0] tx_rdata;
  logic        tx_err;
  logic [3:0]  tx_be;
  logic [31:0] tx_wd;
  logic [31:0] last_rdata;
  logic        last_err;

  logic        lit_en;
  logic        lit_bus;
  int          lit_r;
  logic [31:0] lit_rdata;
  logic        lit_err;
  logic [31:0] lit_addr;
  logic [3:0]  lit_be;
  logic [31:0] lit_wdata;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, k, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] tn, input int a, input logic [31:0] r);
    logic [31:0] v;
    case (tn)
      3'd1, 3'd2: begin
        v = (r >> (16 * (a / 2))) & 32'h0000_FFFF;
        if (tn == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      3'd3, 3'd4: begin
        v = (r >> (8 * a)) & 32'h0000_00FF;
        if (tn == 3'd3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] tn, input int a);
    if (!we) return 4'hF;
    case (tn)
      3'd1, 3'd2: return (a >= 2) ? 4'hC : 4'h3;
      3'd3, 3'd4: return 4'(1 << a);
      default:    return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] tn, input logic [31:0] w);
    case (tn)
      3'd1, 3'd2: return 32'(w[15:0]) * 32'h0001_0001;
      3'd3, 3'd4: return 32'(w[7:0]) * 32'h0101_0101;
      default:    return w;
    endcase
  endfunction

  // Per-cycle compare: every output checked against the model in each observed cycle.
  always @(negedge clk) begin
    if (mode == M_IDLE) begin
      chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
      chk("idle_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      chk("idle_cpu_stall", 32'(bus.cpu_stall), 32'd0);
      chk("hold_cpu_rdata", bus.cpu_rdata, last_rdata);
      chk("hold_cpu_err", 32'(bus.cpu_err), 32'(last_err));
    end else if (mode == M_TXN && k < tx_abort) begin
      chk("cpu_stall", 32'(bus.cpu_stall), (k < tx_r) ? 32'd1 : 32'd0);
      if (k == tx_r) begin
        chk("cpu_ready", 32'(bus.cpu_ready), 32'd1);
        chk("cpu_rdata", bus.cpu_rdata, tx_rdata);
        chk("cpu_err", 32'(bus.cpu_err), 32'(tx_err));
        last_rdata = tx_rdata;
        last_err   = tx_err;
      end else begin
        chk("cpu_ready_low", 32'(bus.cpu_ready), 32'd0);
        chk("hold_cpu_rdata", bus.cpu_rdata, last_rdata);
        chk("hold_cpu_err", 32'(bus.cpu_err), 32'(last_err));
      end
      if (!tx_mis && k >= 1 && k < tx_r) begin
        chk("mem_req", 32'(bus.mem_req), 32'd1);
        chk("mem_we", 32'(bus.mem_we), 32'(tx_we));
        chk("mem_addr", bus.mem_addr, tx_addr & 32'hFFFF_FFFC);
        chk("mem_be", 32'(bus.mem_be), 32'(tx_be));
        if (tx_we) chk("mem_wdata", bus.mem_wdata, tx_wd);
      end else begin
        chk("mem_req_low", 32'(bus.mem_req), 32'd0);
      end
      if (lit_en) begin
        if (k == lit_r) begin
          chk("lit_ready", 32'(bus.cpu_ready), 32'd1);
          chk("lit_rdata", bus.cpu_rdata, lit_rdata);
          chk("lit_err", 32'(bus.cpu_err), 32'(lit_err));
        end
        if (k == 1 && lit_bus) begin
          chk("lit_mem_addr", bus.mem_addr, lit_addr);
          chk("lit_mem_be", 32'(bus.mem_be), 32'(lit_be));
          if (tx_we) chk("lit_mem_wdata", bus.mem_wdata, lit_wdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mode          = M_IDLE;
      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_addr  = $urandom;
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic set_lit(input logic [31:0] rd, input logic er, input int r, input logic bus_chk,
                         input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd);
    lit_en    = 1'b1;
    lit_rdata = rd;
    lit_err   = er;
    lit_r     = r;
    lit_bus   = bus_chk;
    lit_addr  = ad;
    lit_be    = be;
    lit_wdata = wd;
  endtask

  // One CPU access; d = extra cycles before ack, abort_k > 0 pulls reset in cycle abort_k-1.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] t, input int d, input logic [31:0] rd, input int abort_k);
    logic [2:0] tn;
    tn      = (t > 3'd4) ? 3'd0 : t;
    tx_we   = we;
    tx_addr = addr;
    tx_mis  = (tn == 3'd0 && addr[1:0] != 2'b00) || ((tn == 3'd1 || tn == 3'd2) && addr[0]);
    tx_be   = model_be(we, tn, int'(addr[1:0]));
    tx_wd   = model_wdata(tn, wdata);
    if (tx_mis) begin
      tx_r = 1; tx_err = 1'b1; tx_rdata = '0;
    end else if (TMO > 0 && d >= TMO) begin
      tx_r = TMO + 1; tx_err = 1'b1; tx_rdata = '0;
    end else begin
      tx_r = d + 2; tx_err = 1'b0;
      tx_rdata = we ? 32'd0 : model_load(tn, int'(addr[1:0]), rd);
    end
    tx_abort = (abort_k > 0) ? abort_k : 32'h4000_0000;
    for (int i = 0; i <= tx_r; i++) begin
      @(posedge clk); #1;
      mode           = M_TXN;
      k              = i;
      rst            = 1'b1;
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = we;
      bus.cpu_addr   = addr;
      bus.cpu_wdata  = wdata;
      bus.cpu_dmtype = t;
      bus.mem_ack    = !tx_mis && (i == d + 1) && (i < tx_r);
      bus.mem_rdata  = bus.mem_ack ? rd : $urandom;
      if (abort_k > 0 && i == abort_k - 1) begin
        rst = 1'b0;
        break;
      end
    end
    @(negedge clk); #1;
    lit_en = 1'b0;
  endtask

  initial begin
    mode           = M_SKIP;
    k              = 0;
    rst            = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_dmtype = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    last_rdata     = '0;
    last_err       = 1'b0;
    lit_en         = 1'b0;
    tx_abort       = 0;

    @(posedge clk); #1;
    mode = M_IDLE;
    idle(3);

    set_lit(32'hFFFF_FF80, 1'b0, 2, 1'b1, 32'h0000_1000, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_1003, $urandom, 3'b011, 0, 32'h80FF_1234, 0);
    set_lit(32'h0000_BEEF, 1'b0, 2, 1'b1, 32'h0000_2000, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_2002, $urandom, 3'b010, 0, 32'hBEEF_0001, 0);
    set_lit(32'hFFFF_BEEF, 1'b0, 2, 1'b1, 32'h0000_2000, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_2002, $urandom, 3'b001, 0, 32'hBEEF_0001, 0);
    set_lit(32'h0, 1'b0, 2, 1'b1, 32'h0, 4'b0010, 32'hABAB_ABAB);
    run_txn(1'b1, 32'h0000_0001, 32'h1234_56AB, 3'b011, 0, $urandom, 0);
    set_lit(32'h0, 1'b0, 2, 1'b1, 32'h0, 4'b1100, 32'h56AB_56AB);
    run_txn(1'b1, 32'h0000_0002, 32'h1234_56AB, 3'b001, 0, $urandom, 0);
    idle(1);
    set_lit(32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, 32'h0);
    run_txn(1'b0, 32'h0000_0006, $urandom, 3'b000, 0, $urandom, 0);
    set_lit(32'hCAFE_0123, 1'b0, 7, 1'b1, 32'h0000_0040, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_0040, $urandom, 3'b000, 5, 32'hCAFE_0123, 0);

    // Reset in the 3rd WAIT cycle, then a late ack that must be ignored.
    run_txn(1'b0, 32'h0000_0080, $urandom, 3'b000, 5, 32'h1111_2222, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        last_rdata = '0;
        last_err   = 1'b0;
      end
      mode          = M_IDLE;
      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
    end
    idle(2);

    set_lit(32'h0000_0055, 1'b0, 17, 1'b1, 32'h0000_0100, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_0100, $urandom, 3'b000, 15, 32'h0000_0055, 0);
`ifdef DM_TIMEOUT_EN
    set_lit(32'h0, 1'b1, 17, 1'b1, 32'h0000_0200, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_0200, $urandom, 3'b000, 1000, 32'hDEAD_BEEF, 0);
    set_lit(32'h0, 1'b1, 17, 1'b1, 32'h0000_0300, 4'hF, 32'h0);
    run_txn(1'b0, 32'h0000_0300, $urandom, 3'b000, 16, 32'hDEAD_BEEF, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  t;
      int          d;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      t = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      run_txn(1'($urandom_range(0, 1)), a, $urandom, t, d, $urandom, 0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
